ipm2l_hsstlp_hs_sync_tx_v1_0: RTL and testbench

//  Source end of a 4-phase-free toggle req/ack handshake for CDC of a multi-bit word.

---
 rtl/ipm2l_hsstlp_hs_sync_tx_v1_0.sv | 86 ++++++++
 tb/tb_ipm2l_hsstlp_hs_sync_tx_v1_0.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipm2l_hsstlp_hs_sync_tx_v1_0.sv
// Source side of a toggle req/ack CDC handshake: captures a word, holds it on tx_data,
// toggles tx_req and waits for the synchronized far-end ack toggle to match.
module ipm2l_hsstlp_hs_sync_tx_v1_0 #(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic [DW-1:0]    s_data,
   output logic             s_ready,
   input  logic             ack_async,
   output logic             tx_req,
   output logic [DW-1:0]    tx_data,
   output logic             busy,
   output logic             err_timeout,
   output logic             err_proto,
   input  logic             err_clr,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam int WCW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WCW-1:0] WC_MAX = WCW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] ack_sr;
   logic                   ack_sync;
   logic [WCW-1:0]         wait_cnt;
   logic                   done;
   logic                   to_hit;
   logic                   proto_hit;

   assign ack_sync  = ack_sr[SYNC_STAGES-1];
   assign s_ready   = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == WAIT) && (ack_sync == tx_req);
   // Fires on the edge where the wait counter reaches TIMEOUT_CYC, and keeps firing once saturated.
   assign to_hit    = (TIMEOUT_CYC > 0) && (state == WAIT) && !done && (wait_cnt >= WC_MAX - 1'b1);
   assign proto_hit = ((state == IDLE) || (state == LOAD)) && (ack_sync != tx_req);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (s_valid) state_nxt = LOAD;
         LOAD:    state_nxt = WAIT;
         WAIT:    if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ack_sr      <= '0;
         tx_req      <= 1'b0;
         tx_data     <= '0;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         err_proto   <= 1'b0;
         xfer_cnt    <= '0;
      end else begin
         state  <= state_nxt;
         ack_sr <= {ack_sr[SYNC_STAGES-2:0], ack_async};
         if ((state == IDLE) && s_valid)
            tx_data <= s_data;
         if (state == LOAD)
            tx_req <= ~tx_req;
         if (state == WAIT) begin
            if (done)
               wait_cnt <= '0;
            else if (wait_cnt != WC_MAX)
               wait_cnt <= wait_cnt + 1'b1;
         end
         if (done)
            xfer_cnt <= xfer_cnt + 1'b1;
         // A new error condition takes priority over a simultaneous clear.
         err_timeout <= to_hit    | (err_timeout & ~err_clr);
         err_proto   <= proto_hit | (err_proto   & ~err_clr);
      end
   end

endmodule

// File: tb/tb_ipm2l_hsstlp_hs_sync_tx_v1_0.sv
// Scoreboard bench for the toggle handshake source: accepted words are queued and
// matched against tx_data at each tx_req edge; completions are checked against a counter model.
module tb_ipm2l_hsstlp_hs_sync_tx_v1_0;

   localparam int DW    = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic [DW-1:0]    s_data = '0;
   logic             s_ready;
   logic             ack_async;
   logic             tx_req;
   logic [DW-1:0]    tx_data;
   logic             busy;
   logic             err_timeout;
   logic             err_proto;
   logic             err_clr = 1'b0;
   logic [CNT_W-1:0] xfer_cnt;

   logic loopback = 1'b0;
   logic ackMan   = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0]    expQ[$];
   logic [CNT_W-1:0] xferModel = '0;
   logic             prevReq   = 1'b0;
   logic             busyPrev  = 1'b0;
   logic             rstPrev   = 1'b1;

   assign ack_async = loopback ? tx_req : ackMan;

   always #5 clk = ~clk;

   ipm2l_hsstlp_hs_sync_tx_v1_0 #(
      .DW(DW), .SYNC_STAGES(2), .TIMEOUT_CYC(16), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .ack_async(ack_async), .tx_req(tx_req), .tx_data(tx_data), .busy(busy),
      .err_timeout(err_timeout), .err_proto(err_proto), .err_clr(err_clr),
      .xfer_cnt(xfer_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers a word and returns just after the edge that accepted it; s_valid is left high.
   task automatic applyStimulus(input logic [DW-1:0] word);
      logic acc;
      int   budget;
      s_valid = 1'b1;
      s_data  = word;
      budget  = 100;
      do begin
         acc = s_ready;
         step();
         budget--;
      end while (!acc && budget > 0);
      if (!acc) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic waitIdle();
      int budget;
      budget = 100;
      while (busy && budget > 0) begin
         step();
         budget--;
      end
      if (busy) checkOutput("idle_timeout", 0, 1);
   endtask

   // Scoreboard: pop an expected word on every tx_req edge, model xfer_cnt on every completion.
   always @(negedge clk) begin
      if (rstPrev) begin
         expQ.delete();
         xferModel = '0;
      end else begin
         if (tx_req !== prevReq) begin
            if (expQ.size() > 0)
               checkOutput("tx_data_at_req", tx_data, expQ.pop_front());
            else
               checkOutput("req_without_word", tx_req, prevReq);
         end
         if (busyPrev && !busy) begin
            xferModel = xferModel + 1'b1;
            checkOutput("xfer_cnt", xfer_cnt, xferModel);
         end
      end
      if (s_valid && s_ready && !rst)
         expQ.push_back(s_data);
      prevReq  = tx_req;
      busyPrev = busy;
      rstPrev  = rst;
   end

   initial begin
      repeat (3) step();
      rst = 1'b0;
      checkOutput("rst_tx_req", tx_req, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_s_ready", s_ready, 1);
      checkOutput("rst_xfer_cnt", xfer_cnt, 0);
      checkOutput("rst_errs", {err_timeout, err_proto}, 0);

      // Single transfer, ack returned 5 cycles after the req edge
      s_valid = 1'b1;
      s_data  = 8'hA5;
      step();
      s_valid = 1'b0;
      s_data  = 8'h5A;
      checkOutput("single_tx_data_n1", tx_data, 8'hA5);
      checkOutput("single_req_n1", tx_req, 0);
      checkOutput("single_ready_n1", s_ready, 0);
      step();
      checkOutput("single_req_n2", tx_req, 1);
      repeat (5) step();
      ackMan = 1'b1;
      step();
      step();
      checkOutput("single_busy_ack2", busy, 1);
      checkOutput("single_data_hold", tx_data, 8'hA5);
      step();
      checkOutput("single_busy_ack3", busy, 0);
      checkOutput("single_ready_done", s_ready, 1);
      checkOutput("single_xfer", xfer_cnt, 1);
      checkOutput("single_no_err", {err_timeout, err_proto}, 0);

      // Back-to-back with loopback ack
      loopback = 1'b1;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      s_valid = 1'b0;
      waitIdle();
      checkOutput("b2b_req_final", tx_req, 0);
      checkOutput("b2b_xfer", xfer_cnt, 4);
      checkOutput("b2b_no_err", {err_timeout, err_proto}, 0);

      // Timeout: ack withheld past 16 WAIT cycles, then returned late
      ackMan   = 1'b0;
      loopback = 1'b0;
      applyStimulus(8'h3C);
      s_valid = 1'b0;
      step();
      repeat (10) step();
      checkOutput("to_not_yet", err_timeout, 0);
      repeat (10) step();
      checkOutput("to_set", err_timeout, 1);
      checkOutput("to_busy", busy, 1);
      ackMan = 1'b1;
      repeat (3) step();
      checkOutput("to_late_done", busy, 0);
      checkOutput("to_sticky", err_timeout, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checkOutput("to_cleared", err_timeout, 0);

      // Spurious ack toggle while idle
      ackMan = 1'b0;
      repeat (4) step();
      checkOutput("proto_set", err_proto, 1);
      checkOutput("proto_req_hold", tx_req, 1);
      checkOutput("proto_idle", busy, 0);
      checkOutput("proto_no_xfer", xfer_cnt, 5);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checkOutput("proto_set_wins", err_proto, 1);
      ackMan = 1'b1;
      repeat (3) step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checkOutput("proto_cleared", err_proto, 0);

      // Reset while waiting for ack
      applyStimulus(8'h77);
      s_valid = 1'b0;
      repeat (3) step();
      checkOutput("rstw_busy_before", busy, 1);
      rst    = 1'b1;
      ackMan = 1'b0;
      step();
      rst = 1'b0;
      checkOutput("rstw_tx_req", tx_req, 0);
      checkOutput("rstw_tx_data", tx_data, 0);
      checkOutput("rstw_busy", busy, 0);
      checkOutput("rstw_s_ready", s_ready, 1);
      checkOutput("rstw_xfer", xfer_cnt, 0);

      // Counter wrap: 17 transfers on a 4-bit counter
      loopback = 1'b1;
      for (int i = 0; i < 17; i++)
         applyStimulus(DW'(8'h40 + i));
      s_valid = 1'b0;
      waitIdle();
      checkOutput("wrap_xfer", xfer_cnt, 1);
      checkOutput("wrap_no_err", {err_timeout, err_proto}, 0);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
